uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Full-duplex 8N1 UART transceiver with a single-wire hardware flow-control pair (rts out, cts in).
- Two instances cross-connect (txd->rxd, rts->cts) to form a point-to-point serial link.
- Transmission is triggered by a change in the parallel txdata input.
- Received bytes are presented on rxdata, which holds the last good byte.

Parameters:
- BIT_CLK, 8, clk cycles per serial bit; legal range 4 and up; counters sized $clog2(BIT_CLK)+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- txdata  in  8  byte to send; a new frame starts whenever txdata differs from the last byte sent.
- txd  out  1  serial output; idle high.
- cts  in  1  clear-to-send; peer ready; sampled only when deciding to start a frame.
- rxd  in  1  serial input; idle high; asynchronous, so it must be synchronized.
- rxdata  out  8  last correctly received byte.
- rts  out  1  ready-to-send to peer; high while the receiver is idle.

Behaviour:
- Reset values:
  - txd=1, rts=0 (rts goes high the cycle after rst deasserts), rxdata=0x00.
  - last_sent=0x00, so txdata=0 after reset sends nothing.
  - Both FSMs go to IDLE; synchronizer flops are preset to 1.
  - Reset mid-frame aborts immediately; txd goes high on the next edge.
- Frame format: start bit 0, data[0]..data[7] (LSB first), stop bit 1. Each bit lasts exactly BIT_CLK cycles, so a frame is 10*BIT_CLK cycles.
- TX FSM: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
  - In IDLE, if txdata != last_sent and cts==1, latch txdata into the shift register and into last_sent, and go to START.
  - txd falls on that same edge, giving 1-cycle latency from the sampled change.
  - txdata changes during a frame do not disturb it. After STOP the FSM returns to IDLE for at least 1 cycle, then compares again.
  - If txdata changes several times during one frame, only the latest value is sent.
  - cts low in IDLE holds the frame off until cts rises. cts dropping mid-frame has no effect.
  - Writing the same value again does not retransmit.
- RX path: 2-flop synchronizer on rxd. FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - In IDLE, a synchronized low level starts START, and rts drops on the next edge.
  - START waits BIT_CLK/2 cycles and resamples. If rxd is high, it was a glitch: return to IDLE, rxdata unchanged.
  - Otherwise sample each data bit at mid-bit, every BIT_CLK cycles, shifting LSB first.
  - STOP samples mid-bit. If 1, rxdata updates on that edge. If 0 (framing error), discard the byte and leave rxdata unchanged.
  - After a framing error, wait for rxd to go high before re-arming.
  - rts returns high the cycle after the FSM re-enters IDLE.
- TX and RX are fully independent; simultaneous send and receive are allowed.
- No parity, no FIFO, no error output.

Decomposition:
- Package uart_pkg:
  - tx_state_t and rx_state_t enums (IDLE, START, DATA, STOP).
  - Constants DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- One natural sub-module: uart_rx (synchronizer, RX FSM, rxdata/rts).
- TX logic stays in uart_core.

Test Plan:
- Reset, then hold txdata=0 for 20*BIT_CLK cycles -> txd stays 1, rxdata=0x00, rts=1 after reset.
- Two instances looped back; txdata1=0x77 -> txd1 shows 0,1,1,1,0,1,1,1,0,1, each bit BIT_CLK cycles. u2.rxdata=0x77 about 9.5*BIT_CLK+3 cycles after the start edge. u2.rts is low during the frame.
- With txdata1=0xAA, change txdata1 to 0x33 mid-frame -> 0xAA completes intact, then 0x33 follows after ≥1 idle cycle. u2.rxdata goes 0xAA then 0x33.
- Hold cts=0, set txdata=0x55 -> txd stays 1. Raise cts -> start bit appears 1 cycle later.
- Drive rxd low for BIT_CLK/2-1 cycles only -> rxdata unchanged, receiver re-arms. Then a frame with stop bit 0 -> rxdata unchanged.
- Simultaneous txdata1=0x12 and txdata2=0x34 -> u2.rxdata=0x12 and u1.rxdata=0x34. Assert rst mid-frame -> txd=1 next edge, rxdata=0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types and frame constants for the 8N1 UART
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: rxd synchronizer, mid-bit sampling receive FSM, rxdata hold and rts
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_CLK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rxdata,
    output logic       rts
);
    localparam int W = $clog2(BIT_CLK) + 1;
    rx_state_t state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, rxdata_q, rxdata_d;
    logic s1_q, s2_q, err_q, err_d, rts_q;
    logic half_end, bit_end;
    assign half_end = cnt_q == W'(BIT_CLK / 2 - 1);
    assign bit_end = cnt_q == W'(BIT_CLK - 1);
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + W'(1);
        bit_d = bit_q;
        shift_d = shift_q;
        rxdata_d = rxdata_q;
        err_d = err_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                err_d = err_q & ~s2_q;
                if (!err_q && !s2_q) state_d = RX_START;
            end
            RX_START: if (half_end) begin
                cnt_d = '0;
                bit_d = '0;
                state_d = s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (bit_end) begin
                cnt_d = '0;
                shift_d = {s2_q, shift_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
            end
            RX_STOP: if (bit_end) begin
                cnt_d = '0;
                state_d = RX_IDLE;
                // a bad stop bit drops the byte and blocks re-arming until the line idles high
                if (s2_q == STOP_BIT) rxdata_d = shift_q;
                else err_d = 1'b1;
            end
            default: state_d = RX_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            rxdata_q <= '0;
            err_q <= 1'b0;
            rts_q <= 1'b0;
        end else begin
            s1_q <= rxd;
            s2_q <= s1_q;
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            rxdata_q <= rxdata_d;
            err_q <= err_d;
            rts_q <= state_q == RX_IDLE;
        end
    end
    assign rxdata = rxdata_q;
    assign rts = rts_q;
endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 UART transceiver; a frame starts whenever txdata differs from the last byte sent
module uart_core
    import uart_pkg::*;
#(
    parameter int BIT_CLK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txdata,
    output logic       txd,
    input  logic       cts,
    input  logic       rxd,
    output logic [7:0] rxdata,
    output logic       rts
);
    localparam int W = $clog2(BIT_CLK) + 1;
    tx_state_t state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, last_q, last_d;
    logic txd_q, txd_d, bit_end;
    assign bit_end = cnt_q == W'(BIT_CLK - 1);
    always_comb begin
        state_d = state_q;
        cnt_d = bit_end ? '0 : cnt_q + W'(1);
        bit_d = bit_q;
        shift_d = shift_q;
        last_d = last_q;
        txd_d = txd_q;
        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (txdata != last_q && cts) begin
                    state_d = TX_START;
                    shift_d = txdata;
                    last_d = txdata;
                    txd_d = START_BIT;
                end
            end
            TX_START: if (bit_end) begin
                state_d = TX_DATA;
                bit_d = '0;
                txd_d = shift_q[0];
                shift_d = shift_q >> 1;
            end
            TX_DATA: if (bit_end) begin
                if (bit_q == 3'(DATA_BITS - 1)) begin
                    state_d = TX_STOP;
                    txd_d = STOP_BIT;
                end else begin
                    bit_d = bit_q + 3'd1;
                    txd_d = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            TX_STOP: if (bit_end) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            last_q <= '0;
            txd_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            last_q <= last_d;
            txd_q <= txd_d;
        end
    end
    assign txd = txd_q;
    uart_rx #(.BIT_CLK(BIT_CLK)) u_rx (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .rxdata(rxdata),
        .rts(rts)
    );
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: two cross-connected uart_core instances with a byte scoreboard per receiver
module tb_uart_core;
    localparam int B = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] txdata1 = '0, txdata2 = '0, rxdata1, rxdata2;
    logic txd1, txd2, rts1, rts2;
    logic cts_force = 1'b0, cts_ovr = 1'b1, rxd_en = 1'b0, rxd_ovr = 1'b1;
    logic [7:0] prev1 = '0, prev2 = '0;
    logic [7:0] q1[$], q2[$];
    int ncmp = 0, nfail = 0, cyc = 0, arr2 = 0, e_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_core #(.BIT_CLK(B)) u1 (
        .clk(clk), .rst(rst), .txdata(txdata1), .txd(txd1),
        .cts(cts_force ? cts_ovr : rts2), .rxd(txd2), .rxdata(rxdata1), .rts(rts1)
    );
    uart_core #(.BIT_CLK(B)) u2 (
        .clk(clk), .rst(rst), .txdata(txdata2), .txd(txd2),
        .cts(rts1), .rxd(rxd_en ? rxd_ovr : txd1), .rxdata(rxdata2), .rts(rts2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev1 = rxdata1;
            prev2 = rxdata2;
        end else begin
            if (rxdata2 !== prev2) begin
                arr2 = cyc;
                if (q2.size() == 0) chk("rx2_unexpected", rxdata2, prev2);
                else chk("rx2_byte", rxdata2, q2.pop_front());
                prev2 = rxdata2;
            end
            if (rxdata1 !== prev1) begin
                if (q1.size() == 0) chk("rx1_unexpected", rxdata1, prev1);
                else chk("rx1_byte", rxdata1, q1.pop_front());
                prev1 = rxdata1;
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 40 * B) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, q1.size() + q2.size(), 0);
        repeat (2 * B) @(negedge clk);
    endtask

    task automatic idle_watch(input string tag, input int n);
        logic low = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (!txd1 || !txd2) low = 1'b1;
        end
        chk(tag, low, 1'b0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        rxd_ovr = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_ovr = d[i];
            repeat (B) @(negedge clk);
        end
        rxd_ovr = stop;
        repeat (B) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] fr;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd1, 1'b1);
        chk("rst_rts", rts1, 1'b0);
        chk("rst_rxdata", rxdata2, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("rts_after_rst", {rts1, rts2}, 2'b11);
        idle_watch("idle_txd_zero", 20 * B);
        chk("idle_rxdata", rxdata2, 8'h00);

        q2.push_back(8'h77);
        txdata1 = 8'h77;
        fr = {1'b1, 8'h77, 1'b0};
        @(posedge clk);
        @(negedge clk);
        e_cyc = cyc;
        chk("start_latency", txd1, 1'b0);
        repeat (B / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bit%0d", k), txd1, fr[k]);
            if (k == 5) chk("rts2_busy", rts2, 1'b0);
            if (k < 9) repeat (B) @(negedge clk);
        end
        drain("x77");
        chk("rx_latency", arr2 - e_cyc, 9 * B + B / 2 + 3);

        q2.push_back(8'hAA);
        q2.push_back(8'h33);
        txdata1 = 8'hAA;
        repeat (5 * B) @(negedge clk);
        txdata1 = 8'h33;
        drain("aa_33");
        txdata1 = 8'h33;
        idle_watch("no_resend", 12 * B);

        cts_force = 1'b1;
        cts_ovr = 1'b0;
        txdata1 = 8'h55;
        q2.push_back(8'h55);
        idle_watch("cts_hold", 3 * B);
        cts_ovr = 1'b1;
        @(negedge clk);
        chk("cts_start", txd1, 1'b0);
        cts_ovr = 1'b0;
        drain("cts");
        cts_force = 1'b0;

        rxd_ovr = 1'b1;
        rxd_en = 1'b1;
        repeat (2) @(negedge clk);
        rxd_ovr = 1'b0;
        repeat (B / 2 - 1) @(negedge clk);
        rxd_ovr = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("glitch_rxdata", rxdata2, 8'h55);
        chk("glitch_rts", rts2, 1'b1);
        drive_frame(8'hC3, 1'b0);
        rxd_ovr = 1'b0;
        repeat (2 * B) @(negedge clk);
        rxd_ovr = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("framing_rxdata", rxdata2, 8'h55);
        q2.push_back(8'h5A);
        drive_frame(8'h5A, 1'b1);
        drain("rearm");
        rxd_en = 1'b0;

        q2.push_back(8'h12);
        q1.push_back(8'h34);
        txdata1 = 8'h12;
        txdata2 = 8'h34;
        drain("duplex");

        txdata1 = 8'h9C;
        repeat (3 * B) @(negedge clk);
        rst = 1'b1;
        txdata1 = 8'h00;
        txdata2 = 8'h00;
        @(negedge clk);
        chk("midrst_txd", txd1, 1'b1);
        chk("midrst_rxdata", {rxdata1, rxdata2}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        idle_watch("post_rst_idle", 15 * B);
        chk("post_rst_queues", q1.size() + q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
